// File: rtl/rtype_sequencer.sv
// rtype_sequencer: multi-cycle fetch/decode/execute/write-back controller
// for R-type instructions. It owns the PC, the instruction register (IR)
// and the retired-instruction counter.
// Ports:
//   clk, reset (async, active-low), start
//   imemReq, pc, instrValid, instrCode   instruction fetch side
//   rs1, rs2, rd, aluEn, ALUop, RegWrite datapath controls
//   busy, halted, illegalInstr, instrCount status
// Build option ILLEGAL_HALT_EN: an illegal instruction halts the core
// with pc left at the offending address, instead of being skipped.
module rtype_sequencer #(
  parameter int PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 imemReq,
  output logic [PC_WIDTH-1:0]  pc,
  input  logic                 instrValid,
  input  logic [31:0]          instrCode,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [4:0]           rd,
  output logic                 aluEn,
  output logic [3:0]           ALUop,
  output logic                 RegWrite,
  output logic                 busy,
  output logic                 halted,
  output logic                 illegalInstr,
  output logic [CNT_WIDTH-1:0] instrCount
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALTED
  } state_t;

  state_t      state;
  logic [31:0] ir;
  logic        legal;
  logic [3:0]  dec_op;
  logic        rtype;
  logic [2:0]  f3;
  logic [6:0]  f7;

  assign rs1   = ir[19:15];
  assign rs2   = ir[24:20];
  assign rd    = ir[11:7];
  assign f3    = ir[14:12];
  assign f7    = ir[31:25];
  assign rtype = (ir[6:0] == 7'b0110011);

  always_comb begin
    legal  = 1'b0;
    dec_op = 4'b0000;
    unique case (1'b1)
      rtype && f7 == 7'h00 && f3 == 3'b000:
        begin legal = 1'b1; dec_op = 4'b0010; end
      rtype && f7 == 7'h20 && f3 == 3'b000:
        begin legal = 1'b1; dec_op = 4'b0100; end
      rtype && f7 == 7'h00 && f3 == 3'b001:
        begin legal = 1'b1; dec_op = 4'b0101; end
      rtype && f7 == 7'h00 && f3 == 3'b101:
        begin legal = 1'b1; dec_op = 4'b0110; end
      rtype && f7 == 7'h00 && f3 == 3'b110:
        begin legal = 1'b1; dec_op = 4'b0001; end
      rtype && f7 == 7'h00 && f3 == 3'b111:
        begin legal = 1'b1; dec_op = 4'b0000; end
      default: ;
    endcase
  end

  // Outputs are registered: each transition loads the flags of the
  // state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      ir           <= '0;
      ALUop        <= 4'b0000;
      imemReq      <= 1'b0;
      aluEn        <= 1'b0;
      RegWrite     <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      illegalInstr <= 1'b0;
      instrCount   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= FETCH;
            imemReq <= 1'b1;
            busy    <= 1'b1;
          end
        end
        FETCH: begin
          if (instrValid) begin
            ir      <= instrCode;
            state   <= DECODE;
            imemReq <= 1'b0;
          end
        end
        DECODE: begin
          if (ir == 32'h0) begin
            state  <= HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else if (legal) begin
            ALUop <= dec_op;
            aluEn <= 1'b1;
            state <= EXECUTE;
          end else begin
            illegalInstr <= 1'b1;
`ifdef ILLEGAL_HALT_EN
            state  <= HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
`else
            pc      <= pc + PC_WIDTH'(4);
            state   <= FETCH;
            imemReq <= 1'b1;
`endif
          end
        end
        EXECUTE: begin
          aluEn    <= 1'b0;
          RegWrite <= (rd != 5'd0);
          state    <= WRITEBACK;
        end
        WRITEBACK: begin
          RegWrite <= 1'b0;
          pc       <= pc + PC_WIDTH'(4);
          if (instrCount != '1)
            instrCount <= instrCount + 1'b1;
          state    <= FETCH;
          imemReq  <= 1'b1;
        end
        HALTED: begin
          if (start) begin
            pc           <= RESET_PC;
            instrCount   <= '0;
            illegalInstr <= 1'b0;
            state        <= FETCH;
            imemReq      <= 1'b1;
            busy         <= 1'b1;
            halted       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
